// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - memory and datapath signal bundle for the fetch unit
interface instruction_fetch_unit_if;
    logic [63:0] instructionAddress;
    logic        memReq;
    logic        memReady;
    logic        memValid;
    logic [31:0] memData;
    logic        branchTaken;
    logic [63:0] branchTarget;
    logic        instValid;
    logic [31:0] instruction;
    logic [63:0] instPC;
    logic        instReady;

    modport master (
        output instructionAddress, memReq, instValid, instruction, instPC,
        input  memReady, memValid, memData, branchTaken, branchTarget, instReady
    );

    modport slave (
        input  instructionAddress, memReq, instValid, instruction, instPC,
        output memReady, memValid, memData, branchTaken, branchTarget, instReady
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with 2-entry buffer and redirect
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_ADDR = 64'h0
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [63:0] pc;
    logic [63:0] pc_req;
    logic [63:0] fifo_pc  [0:1];
    logic [31:0] fifo_ins [0:1];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        outstanding;
    logic [1:0]  occupancy;
    logic        mem_req;
    logic        handshake;
    logic        push;
    logic        pop;
    logic        inst_valid;
    logic        branch;
    logic        unused_target_bits;

    assign branch             = bus.branchTaken;
    assign unused_target_bits = ^bus.branchTarget[1:0];

    // A request is in flight whenever the FSM has left FETCH.
    assign outstanding = (state != FETCH);
    assign occupancy   = count + {1'b0, outstanding};
    assign inst_valid  = !reset && (count != 2'd0);
    // Redirect wins over a same-cycle pop so the flushed head is never consumed.
    assign pop         = inst_valid && bus.instReady && !branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        handshake  = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = !reset && (occupancy < 2'd2);
                handshake = mem_req && bus.memReady;
                if (handshake) begin
                    next_state = branch ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (bus.memValid) begin
                    next_state = FETCH;
                    push       = !branch;
                end else if (branch) begin
                    next_state = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.memValid) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_ADDR;
            pc_req <= 64'h0;
        end else begin
            if (branch) begin
                pc <= {bus.branchTarget[63:2], 2'b00};
            end else if (handshake) begin
                pc <= pc + 64'd4;
            end
            if (handshake) begin
                pc_req <= pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (branch) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]  <= pc_req;
            fifo_ins[wr_ptr] <= bus.memData;
        end
    end

    assign bus.instructionAddress = pc;
    assign bus.memReq             = mem_req;
    assign bus.instValid          = inst_valid;
    assign bus.instruction        = inst_valid ? fifo_ins[rd_ptr] : 32'h0;
    assign bus.instPC             = inst_valid ? fifo_pc[rd_ptr]  : 64'h0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    instruction_fetch_unit_if ifc ();
    instruction_fetch_unit_if ifc_b ();

    instruction_fetch_unit #(.RESET_ADDR(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    instruction_fetch_unit #(.RESET_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc_b)
    );

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          budget  = 0;
    logic [63:0] last_hs = '1;

    logic [63:0] exp_pc  [$];
    logic [31:0] exp_ins [$];
    logic [63:0] pend_addr [$];
    int          pend_due  [$];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_inst(input logic [63:0] a);
        exp_pc.push_back(a);
        exp_ins.push_back(word_at(a));
    endtask

    task automatic set_budget(input int n);
        budget       = n;
        ifc.memReady = (n > 0);
    endtask

    // One clock: sample at the falling edge, then drive the memory model just after the rising edge.
    task automatic step();
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        @(negedge clk);
        if (!reset && ifc.instValid && ifc.instReady && !ifc.branchTaken) begin
            vectors++;
            assert (exp_pc.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra: observed pc %0h, expected no instruction", ifc.instPC);
            end
            if (exp_pc.size() != 0) begin
                e_pc  = exp_pc.pop_front();
                e_ins = exp_ins.pop_front();
                chk("sb_pc", ifc.instPC, e_pc);
                chk("sb_ins", {32'h0, ifc.instruction}, {32'h0, e_ins});
            end
        end
        if (!reset && ifc.memReq && ifc.memReady) begin
            pend_addr.push_back(ifc.instructionAddress);
            pend_due.push_back(cyc + lat);
            last_hs = ifc.instructionAddress;
            budget--;
        end
        @(posedge clk);
        #1;
        cyc++;
        ifc.memValid = 1'b0;
        if (pend_addr.size() != 0 && cyc >= pend_due[0]) begin
            ifc.memValid = 1'b1;
            ifc.memData  = word_at(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        ifc.memReady = (budget > 0);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        ifc.branchTaken  = 1'b0;
        ifc.instReady    = 1'b0;
        ifc.memValid     = 1'b0;
        ifc_b.memValid   = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_pc.delete();
        exp_ins.delete();
        last_hs = '1;
        set_budget(0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int limit);
        for (int i = 0; i < limit && exp_pc.size() != 0; i++) step();
        chk(tag, exp_pc.size(), 0);
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        ifc.memReady     = 1'b0;
        ifc.memValid     = 1'b0;
        ifc.memData      = 32'h0;
        ifc.branchTaken  = 1'b0;
        ifc.branchTarget = 64'h0;
        ifc.instReady    = 1'b0;
        ifc_b.memReady     = 1'b1;
        ifc_b.memValid     = 1'b0;
        ifc_b.memData      = 32'h1234_5678;
        ifc_b.branchTaken  = 1'b0;
        ifc_b.branchTarget = 64'h0;
        ifc_b.instReady    = 1'b0;

        // Reset values, including memReq suppressed while reset is held
        reset = 1'b1;
        ifc.branchTaken = 1'b1;
        ifc.branchTarget = 64'h500;
        step();
        step();
        #2;
        chk("rst_memreq", ifc.memReq, 1'b0);
        chk("rst_instvalid", ifc.instValid, 1'b0);
        chk("rst_instruction", ifc.instruction, 0);
        chk("rst_instpc", ifc.instPC, 0);
        chk("rst_addr", ifc.instructionAddress, 64'h0);

        // PC wrap on the second instance
        do_reset();
        #2;
        chk("wrap_first_addr", ifc_b.instructionAddress, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_first_req", ifc_b.memReq, 1'b1);
        step();
        ifc_b.memValid = 1'b1;
        step();
        ifc_b.memValid = 1'b0;
        #2;
        chk("wrap_second_addr", ifc_b.instructionAddress, 64'h0);
        chk("wrap_second_req", ifc_b.memReq, 1'b1);
        chk("wrap_head_pc", ifc_b.instPC, 64'hFFFF_FFFF_FFFF_FFFC);

        // Sequential fetch
        do_reset();
        ifc.instReady = 1'b1;
        lat = 1;
        set_budget(4);
        expect_inst(64'h0);
        expect_inst(64'h4);
        expect_inst(64'h8);
        expect_inst(64'hC);
        drain("seq_drain", 40);
        chk("seq_next_pc", ifc.instructionAddress, 64'h10);

        // Backpressure: buffer fills, requests stop, then drains in order
        do_reset();
        lat = 1;
        set_budget(3);
        expect_inst(64'h0);
        expect_inst(64'h4);
        expect_inst(64'h8);
        for (int i = 0; i < 8; i++) step();
        #2;
        chk("bp_memreq", ifc.memReq, 1'b0);
        chk("bp_instvalid", ifc.instValid, 1'b1);
        chk("bp_head_pc", ifc.instPC, 64'h0);
        chk("bp_head_ins", {32'h0, ifc.instruction}, {32'h0, word_at(64'h0)});
        chk("bp_pc", ifc.instructionAddress, 64'h8);
        step();
        #2;
        chk("bp_hold_pc", ifc.instPC, 64'h0);
        chk("bp_hold_ins", {32'h0, ifc.instruction}, {32'h0, word_at(64'h0)});
        ifc.instReady = 1'b1;
        drain("bp_drain", 30);

        // Redirect while the 0x8 request is outstanding
        do_reset();
        ifc.instReady = 1'b1;
        lat = 3;
        set_budget(3);
        expect_inst(64'h0);
        expect_inst(64'h4);
        expect_inst(64'h100);
        for (int i = 0; i < 40 && last_hs != 64'h8; i++) step();
        chk("rw_saw_req8", last_hs, 64'h8);
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 64'h103;
        set_budget(1);
        step();
        ifc.branchTaken = 1'b0;
        #2;
        chk("rw_discard_memreq", ifc.memReq, 1'b0);
        chk("rw_new_pc", ifc.instructionAddress, 64'h100);
        chk("rw_instvalid", ifc.instValid, 1'b0);
        drain("rw_drain", 40);

        // Redirect in WAIT on the same cycle as the response
        do_reset();
        ifc.instReady = 1'b1;
        lat = 1;
        set_budget(1);
        step();
        chk("rwv_valid_now", ifc.memValid, 1'b1);
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 64'h200;
        step();
        ifc.branchTaken = 1'b0;
        #2;
        chk("rwv_memreq", ifc.memReq, 1'b1);
        chk("rwv_instvalid", ifc.instValid, 1'b0);
        chk("rwv_pc", ifc.instructionAddress, 64'h200);
        drain("rwv_drain", 4);

        // Redirect coinciding with the 0x4 handshake; also wins over the pop of 0x0
        do_reset();
        ifc.instReady = 1'b1;
        lat = 2;
        set_budget(3);
        expect_inst(64'h40);
        for (int i = 0; i < 20; i++) begin
            step();
            #2;
            if (ifc.memReq && ifc.memReady && ifc.instructionAddress == 64'h4) break;
        end
        chk("rh_at_req4", ifc.instructionAddress, 64'h4);
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 64'h40;
        step();
        ifc.branchTaken = 1'b0;
        #2;
        chk("rh_discard_memreq", ifc.memReq, 1'b0);
        chk("rh_flushed", ifc.instValid, 1'b0);
        chk("rh_pc", ifc.instructionAddress, 64'h40);
        for (int i = 0; i < 30 && !ifc.instValid; i++) begin
            step();
            #2;
        end
        chk("rh_valid", ifc.instValid, 1'b1);
        chk("rh_first_pc", ifc.instPC, 64'h40);
        chk("rh_first_ins", {32'h0, ifc.instruction}, {32'h0, word_at(64'h40)});
        drain("rh_drain", 10);

        // Reset during WAIT, overriding a same-cycle redirect
        do_reset();
        lat = 5;
        set_budget(1);
        step();
        reset = 1'b1;
        ifc.branchTaken  = 1'b1;
        ifc.branchTarget = 64'h300;
        #2;
        chk("mr_memreq_in_reset", ifc.memReq, 1'b0);
        step();
        reset = 1'b0;
        ifc.branchTaken = 1'b0;
        ifc.memValid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        #2;
        chk("mr_fetch", ifc.memReq, 1'b1);
        chk("mr_pc", ifc.instructionAddress, 64'h0);
        chk("mr_instvalid", ifc.instValid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_ADDR, 64'h0, value loaded into the fetch PC on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: instructionAddress  output  64  address presented to instruction memory.
REQ-005 Port: memReq  output  1  request valid; address is accepted when memReq && memReady.
REQ-006 Port: memReady  input  1  memory accepts the request this cycle.
REQ-007 Port: memValid  input  1  memData is valid this cycle; responses arrive in order, at least 1 cycle after acceptance.
REQ-008 Port: memData  input  32  returned instruction word.
REQ-009 Port: branchTaken  input  1  redirect request from the datapath.
REQ-010 Port: branchTarget  input  64  redirect address; bits [1:0] are ignored and treated as 0.
REQ-011 Port: instValid  output  1  buffer head holds a valid instruction.
REQ-012 Port: instruction  output  32  instruction at the buffer head.
REQ-013 Port: instPC  output  64  address of the buffer-head instruction.
REQ-014 Port: instReady  input  1  datapath consumes the head when instValid && instReady.

Function
REQ-015 The block SHALL hold a fetch PC, a 2-entry FIFO of {pc, instruction}, and an FSM with states FETCH, WAIT, and DISCARD.
REQ-016 instructionAddress SHALL always equal the fetch PC.
REQ-017 In FETCH, memReq SHALL be 1 iff (FIFO count + outstanding) < 2; outstanding is at most 1.
REQ-018 On handshake in FETCH without redirect: the block SHALL latch pc_req = PC, set PC = PC + 4 (64-bit, wrap modulo 2^64), and go to WAIT.
REQ-019 In WAIT, memReq SHALL be 0; on memValid without redirect, {pc_req, memData} SHALL be pushed and the FSM SHALL return to FETCH.
REQ-020 On branchTaken in any state: FIFO SHALL flush (count = 0, instValid = 0 next cycle), and PC SHALL become {branchTarget[63:2], 2'b00}.
REQ-021 Redirect in FETCH with no handshake -> stay FETCH; memReq SHALL be allowed the next cycle with the new PC.
REQ-022 Redirect in FETCH coinciding with a handshake -> the accepted request SHALL be stale; go to DISCARD.
REQ-023 Redirect in WAIT without memValid -> DISCARD; with memValid the same cycle -> data dropped, go FETCH.
REQ-024 In DISCARD, memReq SHALL be 0; memValid SHALL be dropped (no push) and the FSM SHALL go to FETCH; a further redirect SHALL update the PC only.
REQ-025 A redirect SHALL take priority over a same-cycle pop and push; neither SHALL take effect.
REQ-026 A simultaneous push and pop SHALL leave the count unchanged and preserve order; a push into a full FIFO SHALL not occur (guaranteed by REQ-017).
REQ-027 Fetch-to-instValid latency SHALL be: handshake at cycle N, memValid at cycle M > N, instValid = 1 at cycle M+1.
REQ-028 The instruction and instPC outputs SHALL be stable while instValid && !instReady.

Reset
REQ-029 When reset is 1 at an edge, the block SHALL set PC = RESET_ADDR, FSM = FETCH, FIFO count = 0, outstanding = 0.
REQ-030 Reset outputs SHALL be: instValid = 0, memReq = 0 during the reset cycle, instruction = 0, and instPC = 0.
REQ-031 Reset SHALL override branchTaken; a response arriving after reset for a pre-reset request is excluded by system contract and need not be handled.

Verification
REQ-032 Sequential fetch: memReady = 1, 1-cycle memValid, instReady = 1 -> instPC sequence 0x0, 0x4, 0x8, 0xC with the matching memData words.
REQ-033 Backpressure: instReady = 0 after 2 pushes -> memReq = 0, FIFO holds PCs 0x0 and 0x4; release instReady -> both pop in order, then fetch resumes at 0x8.
REQ-034 Redirect in WAIT: request for 0x8 outstanding, branchTaken with target 0x103 -> response dropped, next request 0x100, next instPC 0x100.
REQ-035 Redirect coinciding with a handshake at 0x4, target 0x40 -> the 0x4 response is discarded, instValid stays 0 until the 0x40 data arrives.
REQ-036 PC wrap: RESET_ADDR = 64'hFFFF_FFFF_FFFF_FFFC -> second request address 0x0.
REQ-037 Mid-operation reset during WAIT -> next cycle: FETCH, PC = RESET_ADDR, instValid = 0.
